// File: rtl/md_sched.sv
`default_nettype none
//============================================================================
// Module   : md_sched
// Purpose  : Multiply/divide unit scheduler. Launches mult/multu/div/divu
//            into a multi-cycle datapath. While an operation is in flight it
//            stalls any further HI/LO-class instruction in the E stage. It
//            pulses commit in the last busy cycle so the datapath copies its
//            temporary results into HI/LO. It also issues direct HI/LO write
//            enables for mthi/mtlo when the unit is idle.
// Options  : `define MD_FLUSH_EN enables the flush input. A flush cancels an
//            in-flight operation (abort pulse, no commit) and suppresses any
//            new launch or HI/LO write in that cycle. Without the macro, flush
//            is ignored and abort is tied low.
// Ports    : clk       - sole clock, rising edge
//            reset     - asynchronous, active-low reset
//            op_valid  - E stage holds a mul/div-class instruction
//            op_type   - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi,
//                        6 mflo, 7 mthi, 8 mtlo, 9..15 treated as none
//            flush     - pipeline flush (MD_FLUSH_EN builds only)
//            start     - one-cycle launch pulse to the datapath
//            start_op  - op_type captured at the last launch
//            busy      - operation in flight
//            stall     - freeze E stage and everything upstream
//            commit    - one-cycle pulse: copy temp results into HI/LO
//            hi_we     - write HI from rs this cycle (mthi)
//            lo_we     - write LO from rs this cycle (mtlo)
//            remain    - busy cycles left including current, 0 when idle
//            abort     - one-cycle pulse: in-flight operation cancelled
// Revision : 1.0 - initial release
//============================================================================
module md_sched #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_valid,
    input  logic [3:0] op_type,
    input  logic       flush,
    output logic       start,
    output logic [3:0] start_op,
    output logic       busy,
    output logic       stall,
    output logic       commit,
    output logic       hi_we,
    output logic       lo_we,
    output logic [3:0] remain,
    output logic       abort
);

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MTHI  = 4'd7;
    localparam logic [3:0] c_OP_MTLO  = 4'd8;
    localparam logic [3:0] c_MULT_LAT = 4'(MULT_LAT);
    localparam logic [3:0] c_DIV_LAT  = 4'(DIV_LAT);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t     r_state;
    logic [3:0] r_remain;
    logic [3:0] r_start_op;

    logic w_idle;
    logic w_run;
    logic w_is_md;
    logic w_is_hilo;
    logic w_flush;
    logic w_start;
    logic w_last;

    // Flush handling is compiled in only when requested. Otherwise the input
    // is deliberately left without effect.
`ifdef MD_FLUSH_EN
    assign w_flush = flush;
`else
    logic w_unused_flush;
    assign w_unused_flush = flush;
    assign w_flush        = 1'b0;
`endif

    assign w_idle    = (r_state == ST_IDLE);
    assign w_run     = (r_state == ST_RUN);

    // Only codes 1..4 launch the datapath. Codes 1..8 all touch HI/LO, so
    // they must wait for an in-flight operation. Codes 9..15 fall outside
    // both ranges and therefore behave as "none".
    assign w_is_md   = (op_type >= c_OP_MULT) && (op_type <= c_OP_DIVU);
    assign w_is_hilo = (op_type >= c_OP_MULT) && (op_type <= c_OP_MTLO);

    // reset gates the idle-side decodes. The state register already reads
    // IDLE while reset is held, so without this gate an op presented during
    // reset would still launch.
    assign w_start = reset && w_idle && op_valid && w_is_md && !w_flush;
    assign w_last  = w_run && (r_remain == 4'd1);

    assign start    = w_start;
    assign hi_we    = reset && w_idle && op_valid && (op_type == c_OP_MTHI) && !w_flush;
    assign lo_we    = reset && w_idle && op_valid && (op_type == c_OP_MTLO) && !w_flush;
    assign busy     = w_run;
    // The launch cycle is still IDLE, so it never stalls. The commit cycle is
    // still RUN, so an op arriving there waits exactly one cycle.
    assign stall    = w_run && op_valid && w_is_hilo;
    // A flush landing in the commit cycle converts the commit into an abort,
    // so a cancelled result never reaches HI/LO.
    assign commit   = w_last && !w_flush;
    assign abort    = w_run && w_flush;
    assign remain   = r_remain;
    assign start_op = r_start_op;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_remain   <= 4'd0;
            r_start_op <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state    <= ST_RUN;
                        r_start_op <= op_type;
                        r_remain   <= (op_type <= c_OP_MULTU) ? c_MULT_LAT : c_DIV_LAT;
                    end
                end
                ST_RUN: begin
                    if (w_flush || (r_remain <= 4'd1)) begin
                        r_state  <= ST_IDLE;
                        r_remain <= 4'd0;
                    end else begin
                        r_remain <= r_remain - 4'd1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_remain <= 4'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md_sched.sv
`default_nettype none
//============================================================================
// Module   : tb_md_sched
// Purpose  : Self-checking bench for md_sched. A cycle-level countdown model
//            predicts every output; directed scenarios are followed by
//            randomized traffic. Honours MD_FLUSH_EN the same way as the DUT.
// Revision : 1.0 - initial release
//============================================================================
module tb_md_sched;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
`ifdef MD_FLUSH_EN
    localparam bit FLUSH_ON = 1'b1;
`else
    localparam bit FLUSH_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       op_valid;
    logic [3:0] op_type;
    logic       flush;
    logic       start;
    logic [3:0] start_op;
    logic       busy;
    logic       stall;
    logic       commit;
    logic       hi_we;
    logic       lo_we;
    logic [3:0] remain;
    logic       abort;

    always #5 clk = ~clk;

    md_sched #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op_type  (op_type),
        .flush    (flush),
        .start    (start),
        .start_op (start_op),
        .busy     (busy),
        .stall    (stall),
        .commit   (commit),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .remain   (remain),
        .abort    (abort)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: cycles of work left on the unit, and the last launched op.
    int         left = 0;
    logic [3:0] sop  = 4'd0;

    // Observation counters used by the scenario-level checks.
    int cyc_n       = 0;
    int last_commit = -1;
    int n_commit    = 0;
    int n_abort     = 0;
    int n_busy      = 0;
    int n_stall     = 0;
    int n_hi        = 0;
    int n_lo        = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    // One clock cycle: apply inputs, compare against the model, advance the model.
    task automatic cyc(input logic v, input logic [3:0] t, input logic f, input logic r);
        logic       fe, md, any;
        logic       e_start, e_busy, e_stall, e_commit, e_hi, e_lo, e_abort;
        logic [3:0] e_remain, e_sop;
        @(negedge clk);
        reset    = r;
        op_valid = v;
        op_type  = t;
        flush    = f;
        #2;
        fe  = FLUSH_ON && f;
        md  = (t >= 4'd1) && (t <= 4'd4);
        any = (t >= 4'd1) && (t <= 4'd8);
        if (!r) begin
            {e_start, e_busy, e_stall, e_commit, e_hi, e_lo, e_abort} = '0;
            e_remain = 4'd0;
            e_sop    = 4'd0;
        end else begin
            e_busy   = (left > 0);
            e_remain = 4'(left);
            e_sop    = sop;
            e_start  = (left == 0) && v && md && !fe;
            e_hi     = (left == 0) && v && (t == 4'd7) && !fe;
            e_lo     = (left == 0) && v && (t == 4'd8) && !fe;
            e_stall  = (left > 0) && v && any;
            e_commit = (left == 1) && !fe;
            e_abort  = (left > 0) && fe;
        end
        check("start",    32'(start),    32'(e_start));
        check("start_op", 32'(start_op), 32'(e_sop));
        check("busy",     32'(busy),     32'(e_busy));
        check("stall",    32'(stall),    32'(e_stall));
        check("commit",   32'(commit),   32'(e_commit));
        check("hi_we",    32'(hi_we),    32'(e_hi));
        check("lo_we",    32'(lo_we),    32'(e_lo));
        check("remain",   32'(remain),   32'(e_remain));
        check("abort",    32'(abort),    32'(e_abort));
        if (commit) begin n_commit++; last_commit = cyc_n; end
        if (abort)  n_abort++;
        if (busy)   n_busy++;
        if (stall)  n_stall++;
        if (hi_we)  n_hi++;
        if (lo_we)  n_lo++;
        // Model update for the coming rising edge.
        if (!r) begin
            left = 0;
            sop  = 4'd0;
        end else if (left > 0) begin
            left = fe ? 0 : left - 1;
        end else if (e_start) begin
            left = (t <= 4'd2) ? MULT_LAT : DIV_LAT;
            sop  = t;
        end
        cyc_n++;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 1'b0, 1'b1);
    endtask

    initial begin
        int t0, b0, s0, c0, a0, h0, l0, guard;
        reset    = 1'b0;
        op_valid = 1'b0;
        op_type  = 4'd0;
        flush    = 1'b0;

        // Reset with an op presented: nothing may launch.
        cyc(1'b1, 4'd1, 1'b0, 1'b0);
        cyc(1'b1, 4'd7, 1'b0, 1'b0);
        nops(2);

        // mult at cycle 0: busy for 5 cycles, commit in cycle 5.
        t0 = cyc_n; b0 = n_busy;
        cyc(1'b1, 4'd1, 1'b0, 1'b1);
        nops(7);
        check("mult_commit_cycle", 32'(last_commit - t0), 32'd5);
        check("mult_busy_cycles",  32'(n_busy - b0),      32'd5);

        // div, then mflo from cycle 2: stall for cycles 2..10.
        s0 = n_stall;
        cyc(1'b1, 4'd3, 1'b0, 1'b1);
        nops(1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 4'd6, 1'b0, 1'b1);
        nops(2);
        check("div_mflo_stalls", 32'(n_stall - s0), 32'd9);

        // multu, divu in its commit cycle: one stall, then divu launches.
        s0 = n_stall;
        cyc(1'b1, 4'd2, 1'b0, 1'b1);
        guard = 0;
        while (left != 1 && guard < 20) begin nops(1); guard++; end
        cyc(1'b1, 4'd4, 1'b0, 1'b1);
        cyc(1'b1, 4'd4, 1'b0, 1'b1);
        nops(1);
        check("divu_start_op",   32'(start_op),         32'd4);
        check("divu_hold_stall", 32'(n_stall - s0),     32'd1);
        nops(12);

        // mthi when idle writes HI; mtlo while busy only stalls.
        h0 = n_hi; l0 = n_lo;
        cyc(1'b1, 4'd7, 1'b0, 1'b1);
        cyc(1'b1, 4'd1, 1'b0, 1'b1);
        cyc(1'b1, 4'd8, 1'b0, 1'b1);
        cyc(1'b1, 4'd8, 1'b0, 1'b1);
        check("mthi_writes",      32'(n_hi - h0), 32'd1);
        check("mtlo_busy_writes", 32'(n_lo - l0), 32'd0);
        nops(6);

        // Reset at remain = 3 of a div: no commit ever.
        c0 = n_commit;
        cyc(1'b1, 4'd3, 1'b0, 1'b1);
        guard = 0;
        while (left != 3 && guard < 20) begin nops(1); guard++; end
        cyc(1'b0, 4'd0, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 1'b0, 1'b0);
        nops(12);
        check("reset_no_commit", 32'(n_commit - c0), 32'd0);

        // Flush at remain = 4.
        c0 = n_commit; a0 = n_abort;
        cyc(1'b1, 4'd3, 1'b0, 1'b1);
        guard = 0;
        while (left != 4 && guard < 20) begin nops(1); guard++; end
        cyc(1'b0, 4'd0, 1'b1, 1'b1);
        nops(8);
        check("flush_commits", 32'(n_commit - c0), FLUSH_ON ? 32'd0 : 32'd1);
        check("flush_aborts",  32'(n_abort - a0),  FLUSH_ON ? 32'd1 : 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic       v, f, r;
            logic [3:0] t;
            v = ($urandom_range(0, 9) < 7);
            t = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 8)) : 4'($urandom_range(0, 15));
            f = ($urandom_range(0, 19) == 0);
            r = ($urandom_range(0, 99) != 0);
            cyc(v, t, f, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md_sched.md
MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 Parameter MULT_LAT, default 5, busy cycles for mult/multu; legal range 2..15.
REQ-002 Parameter DIV_LAT, default 10, busy cycles for div/divu; legal range 2..15.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 op_valid  input  1  E-stage holds a multiply/divide-class instruction.
REQ-006 op_type  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; codes 9..15 are treated as none.
REQ-007 flush  input  1  pipeline flush request; honoured only when MD_FLUSH_EN is defined.
REQ-008 start  output  1  one-cycle pulse telling the datapath to launch the operation.
REQ-009 start_op  output  4  op_type captured at start; held until the next start.
REQ-010 busy  output  1  an operation is in flight.
REQ-011 stall  output  1  freeze the E stage and everything upstream of it.
REQ-012 commit  output  1  one-cycle pulse: datapath copies its temporary results into HI/LO.
REQ-013 hi_we  output  1  write HI from rs this cycle (mthi).
REQ-014 lo_we  output  1  write LO from rs this cycle (mtlo).
REQ-015 remain  output  4  busy cycles left, including the current one; 0 when idle.
REQ-016 abort  output  1  one-cycle pulse: an in-flight operation was cancelled.

Function
REQ-017 The FSM has exactly two states: IDLE and RUN.
REQ-018 start = 1 when state is IDLE, op_valid = 1 and op_type is 1..4; otherwise start = 0.
REQ-019 On a start edge: RUN is entered, remain is loaded with MULT_LAT (types 1, 2) or DIV_LAT (types 3, 4), and start_op is captured.
REQ-020 In RUN, remain decrements by 1 each edge; commit = 1 exactly when remain == 1, and the next edge enters IDLE with remain = 0.
REQ-021 busy = 1 exactly while in RUN, so it is high for LAT consecutive cycles after the start edge, including the commit cycle.
REQ-022 stall = busy and op_valid and (op_type in 1..8); the start cycle itself does not stall.
REQ-023 An op presented in the commit cycle stalls that cycle and is accepted on the following cycle, which is in IDLE.
REQ-024 hi_we = IDLE and op_valid and op_type == 7; lo_we = IDLE and op_valid and op_type == 8; both are combinational and can never be high together.
REQ-025 mfhi/mflo in IDLE produce no start, no write enable and no stall.
REQ-026 op_type none or an illegal code never produces start, stall, hi_we or lo_we.
REQ-027 The datapath HI/LO is written only on commit, hi_we or lo_we; the result of an aborted operation is never committed.

Reset
REQ-028 When reset = 0, the block asynchronously enters IDLE and sets remain = 0, start_op = 0, busy = 0, stall = 0, commit = 0, start = 0, hi_we = 0, lo_we = 0, abort = 0.
REQ-029 Reset asserted in the middle of RUN discards the operation with no commit; the block restarts in IDLE on the first edge after reset = 1.

Configuration
REQ-030 With macro MD_FLUSH_EN defined:
- flush = 1 in RUN: the next edge enters IDLE, remain = 0, and no commit is issued.
- abort pulses in that flush cycle.
- flush = 1 in IDLE: start, hi_we and lo_we are suppressed for that cycle.
- flush in the commit cycle: commit is suppressed and abort is raised instead.
REQ-031 With MD_FLUSH_EN undefined: flush is ignored and abort is tied to 0.

Verification
REQ-032 mult at cycle 0 -> start = 1 at cycle 0; busy high cycles 1..5; commit = 1 at cycle 5; idle at cycle 6.
REQ-033 div then mflo at cycle 2 -> stall = 1 for cycles 2..10, remain counting 9 down to 1; stall = 0 at cycle 11.
REQ-034 multu, then divu presented in the commit cycle -> stall for 1 cycle; divu start on the next cycle; start_op = 4.
REQ-035 mthi in IDLE -> hi_we = 1 for one cycle with start = 0 and stall = 0; mtlo while busy -> stall = 1 and lo_we = 0.
REQ-036 reset = 0 at remain = 3 of a div -> all outputs 0 immediately; commit never pulses.
REQ-037 MD_FLUSH_EN build, flush at remain = 4 -> abort = 1, IDLE next edge, no commit; with the macro undefined the same stimulus commits normally.
